// File: rtl/yarp_mem_arbiter.sv
// Two-master (fetch/load-store) arbiter onto a single memory port.
// One transaction is outstanding at a time; data wins unless fetch has starved.
module yarp_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_gnt_o,
  output logic        imem_rvalid_o,
  output logic [31:0] imem_rdata_o,

  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_be_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic        data_win_s, inst_win_s;
  logic        data_gnt_s, inst_gnt_s;

  logic        mem_req_s, mem_we_s;
  logic [31:0] mem_addr_s, mem_wdata_s;
  logic [3:0]  mem_be_s;
  logic        imem_gnt_s, dmem_gnt_s;
  logic        imem_rvalid_s, dmem_rvalid_s;
  logic [31:0] imem_rdata_s, dmem_rdata_s;

  // Arbitration, request mux, response routing and next state.
  always_comb begin
    // Data also wins once fetch withdraws, so a saturated count can never leave a request unserved.
    data_win_s    = dmem_req_i && ((starve_cnt_q < LIMIT) || !imem_req_i);
    inst_win_s    = imem_req_i && !data_win_s;
    data_gnt_s    = 1'b0;
    inst_gnt_s    = 1'b0;
    state_d       = state_q;
    mem_req_s     = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = 32'h0000_0000;
    mem_wdata_s   = 32'h0000_0000;
    mem_be_s      = 4'h0;
    imem_gnt_s    = 1'b0;
    dmem_gnt_s    = 1'b0;
    imem_rvalid_s = 1'b0;
    dmem_rvalid_s = 1'b0;
    imem_rdata_s  = 32'h0000_0000;
    dmem_rdata_s  = 32'h0000_0000;

    case (state_q)
      IDLE: begin
        mem_req_s = imem_req_i | dmem_req_i;
        if (data_win_s) begin
          mem_we_s    = dmem_we_i;
          mem_addr_s  = dmem_addr_i;
          mem_wdata_s = dmem_wdata_i;
          mem_be_s    = dmem_be_i;
          dmem_gnt_s  = mem_gnt_i;
          data_gnt_s  = mem_gnt_i;
        end else if (inst_win_s) begin
          mem_addr_s  = imem_addr_i;
          mem_be_s    = 4'hF;
          imem_gnt_s  = mem_gnt_i;
          inst_gnt_s  = mem_gnt_i;
        end else begin
          mem_be_s    = 4'h0;
        end
        // A response arriving here has no owner and is dropped.
        if (data_gnt_s) begin
          state_d = WAIT_D;
        end else if (inst_gnt_s) begin
          state_d = WAIT_I;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_I: begin
        if (mem_rvalid_i) begin
          imem_rvalid_s = 1'b1;
          imem_rdata_s  = mem_rdata_i;
          state_d       = IDLE;
        end else begin
          state_d       = WAIT_I;
        end
      end
      WAIT_D: begin
        if (mem_rvalid_i) begin
          dmem_rvalid_s = 1'b1;
          dmem_rdata_s  = mem_rdata_i;
          state_d       = IDLE;
        end else begin
          state_d       = WAIT_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!imem_req_i || inst_gnt_s) begin
      starve_cnt_d = 4'd0;
    end else if (data_gnt_s) begin
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : (starve_cnt_q + 4'd1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // FSM and starvation counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Outputs are held quiet for the whole reset window, not just after the first edge.
  assign mem_req_o     = reset_n & mem_req_s;
  assign mem_we_o      = reset_n & mem_we_s;
  assign mem_addr_o    = reset_n ? mem_addr_s  : 32'h0000_0000;
  assign mem_wdata_o   = reset_n ? mem_wdata_s : 32'h0000_0000;
  assign mem_be_o      = reset_n ? mem_be_s    : 4'h0;
  assign imem_gnt_o    = reset_n & imem_gnt_s;
  assign dmem_gnt_o    = reset_n & dmem_gnt_s;
  assign imem_rvalid_o = reset_n & imem_rvalid_s;
  assign dmem_rvalid_o = reset_n & dmem_rvalid_s;
  assign imem_rdata_o  = reset_n ? imem_rdata_s : 32'h0000_0000;
  assign dmem_rdata_o  = reset_n ? dmem_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Self-checking bench for yarp_mem_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_yarp_mem_arbiter;

  localparam int LIM = 4;
  localparam logic [137:0] FULL  = {138{1'b1}};
  localparam logic [137:0] WMASK = {1'b1, 69'b0, 68'hF_FFFF_FFFF_FFFF_FFFF};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_i;
  logic [31:0] imem_addr_i;
  logic        imem_gnt_o, imem_rvalid_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_req_i, dmem_we_i;
  logic [31:0] dmem_addr_i, dmem_wdata_i;
  logic [3:0]  dmem_be_i;
  logic        dmem_gnt_o, dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data) and how many
  // data grants fetch has watched go by while waiting.
  int   m_owner = 0;
  int   m_waits = 0;
  logic m_gi, m_gd;

  logic [137:0] e, m;

  yarp_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
    .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_be_i(dmem_be_i), .dmem_gnt_o(dmem_gnt_o),
    .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [137:0] obs_vec();
    return {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
            imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o,
            imem_rdata_o, dmem_rdata_o};
  endfunction

  function automatic void model_exp(output logic [137:0] ev, output logic [137:0] mv);
    logic dwin, iwin;
    ev = '0;
    mv = FULL;
    if (!reset_n) return;
    if (m_owner == 0) begin
      dwin = dmem_req_i && ((m_waits < LIM) || !imem_req_i);
      iwin = imem_req_i && !dwin;
      ev[137] = imem_req_i | dmem_req_i;
      if (dwin) begin
        ev[136]     = dmem_we_i;
        ev[135:104] = dmem_addr_i;
        ev[103:72]  = dmem_wdata_i;
        ev[71:68]   = dmem_be_i;
        ev[66]      = mem_gnt_i;
      end else if (iwin) begin
        ev[135:104] = imem_addr_i;
        ev[71:68]   = 4'hF;
        ev[67]      = mem_gnt_i;
      end else begin
        mv = WMASK;
      end
    end else begin
      mv = WMASK;
      if (mem_rvalid_i && m_owner == 1) begin
        ev[65] = 1'b1;
        ev[63:32] = mem_rdata_i;
      end else if (mem_rvalid_i && m_owner == 2) begin
        ev[64] = 1'b1;
        ev[31:0] = mem_rdata_i;
      end
    end
  endfunction

  function automatic void model_adv();
    logic dwin, iwin;
    m_gi = 1'b0;
    m_gd = 1'b0;
    if (!reset_n) begin
      m_owner = 0;
      m_waits = 0;
      return;
    end
    if (m_owner == 0) begin
      dwin = dmem_req_i && ((m_waits < LIM) || !imem_req_i);
      iwin = imem_req_i && !dwin;
      m_gi = iwin && mem_gnt_i;
      m_gd = dwin && mem_gnt_i;
      if (m_gi) m_owner = 1;
      else if (m_gd) m_owner = 2;
    end else if (mem_rvalid_i) begin
      m_owner = 0;
    end
    if (!imem_req_i || m_gi) m_waits = 0;
    else if (m_gd) m_waits = (m_waits + 1 > LIM) ? LIM : m_waits + 1;
  endfunction

  task automatic cycle();
    model_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_i = 1'b0; imem_addr_i = 32'h0;
    dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = 32'h0;
    dmem_wdata_i = 32'h0; dmem_be_i = 4'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    imem_req_i = 1'b1; dmem_req_i = 1'b1; mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs_vec() !== 138'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d actual=%h required=0", i, obs_vec());
      end
      cycle();
    end
    clear_inputs();
    reset_n = 1'b1;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e) begin
      errors++;
      $display("FAIL reset_release actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
  endtask

  task automatic test_single_fetch();
    clear_inputs();
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_0100; mem_gnt_i = 1'b1;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e || imem_gnt_o !== 1'b1 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin
      errors++;
      $display("FAIL fetch_grant actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
    clear_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0050_0093;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e || imem_rvalid_o !== 1'b1 || imem_rdata_o !== 32'h0050_0093) begin
      errors++;
      $display("FAIL fetch_rvalid actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
    clear_inputs();
  endtask

  task automatic test_store_priority();
    clear_inputs();
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_0104;
    dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h0000_2000;
    dmem_wdata_i = 32'hDEAD_BEEF; dmem_be_i = 4'h3; mem_gnt_i = 1'b1;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e || dmem_gnt_o !== 1'b1 || imem_gnt_o !== 1'b0 ||
        mem_we_o !== 1'b1 || mem_be_o !== 4'h3 || mem_wdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_grant actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
    dmem_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e || dmem_rvalid_o !== 1'b1 || imem_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL store_ack actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
    mem_rvalid_i = 1'b0;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e || imem_gnt_o !== 1'b1 || mem_addr_o !== 32'h0000_0104) begin
      errors++;
      $display("FAIL fetch_after_store actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
    imem_req_i = 1'b0; mem_rvalid_i = 1'b1;
    cycle();
    clear_inputs();
    cycle();
  endtask

  task automatic test_starvation();
    int grants[$];
    clear_inputs();
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_0400;
    dmem_req_i = 1'b1; dmem_addr_i = 32'h0000_0500;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_1234;
    for (int i = 0; i < 20; i++) begin
      #1;
      model_exp(e, m);
      checks++;
      if ((obs_vec() & m) !== e) begin
        errors++;
        $display("FAIL starve_cycle cyc=%0d actual=%h required=%h", i, obs_vec() & m, e);
      end
      if (imem_gnt_o) grants.push_back(1);
      if (dmem_gnt_o) grants.push_back(0);
      cycle();
    end
    checks++;
    if (grants.size() != 10) begin
      errors++;
      $display("FAIL starve_grant_count actual=%0d required=10", grants.size());
    end
    foreach (grants[k]) begin
      checks++;
      if (grants[k] != ((k % 5 == 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL starve_order idx=%0d actual_inst=%0d required_inst=%0d", k, grants[k], (k % 5 == 4) ? 1 : 0);
      end
    end
    clear_inputs();
    mem_rvalid_i = 1'b1;
    cycle();
    clear_inputs();
    cycle();
  endtask

  task automatic test_wait_grant();
    clear_inputs();
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = (i == 3);
      #1;
      model_exp(e, m);
      checks++;
      if ((obs_vec() & m) !== e || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0300 ||
          imem_gnt_o !== (i == 3)) begin
        errors++;
        $display("FAIL stalled_grant cyc=%0d actual=%h required=%h", i, obs_vec() & m, e);
      end
      cycle();
    end
    clear_inputs();
    mem_rvalid_i = 1'b1;
    cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    dmem_req_i = 1'b1; dmem_addr_i = 32'h0000_0800; mem_gnt_i = 1'b1;
    cycle();
    clear_inputs();
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_0900;
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 138'b0) begin
      errors++;
      $display("FAIL reset_async actual=%h required=0", obs_vec());
    end
    cycle();
    checks++;
    if (obs_vec() !== 138'b0) begin
      errors++;
      $display("FAIL reset_held actual=%h required=0", obs_vec());
    end
    reset_n = 1'b1;
    imem_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0BAD;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e || dmem_rvalid_o !== 1'b0 || dmem_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL stale_rvalid actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
    clear_inputs();
    imem_req_i = 1'b1; imem_addr_i = 32'h0000_0A00; mem_gnt_i = 1'b1;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e || imem_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
    clear_inputs();
    mem_rvalid_i = 1'b1;
    cycle();
    clear_inputs();
  endtask

  task automatic test_idle_rvalid();
    clear_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    model_exp(e, m);
    checks++;
    if ((obs_vec() & m) !== e || imem_rvalid_o !== 1'b0 || dmem_rvalid_o !== 1'b0 ||
        imem_rdata_o !== 32'h0 || dmem_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL idle_rvalid actual=%h required=%h", obs_vec() & m, e);
    end
    cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!imem_req_i || m_gi) begin
        imem_req_i  = ($urandom_range(0, 2) != 0);
        imem_addr_i = $urandom;
      end
      if (!dmem_req_i || m_gd) begin
        dmem_req_i   = ($urandom_range(0, 2) != 0);
        dmem_we_i    = $urandom_range(0, 1) == 1;
        dmem_addr_i  = $urandom;
        dmem_wdata_i = $urandom;
        dmem_be_i    = 4'($urandom_range(0, 15));
      end
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = ($urandom_range(0, 2) != 0);
      mem_rdata_i  = $urandom;
      #1;
      model_exp(e, m);
      checks++;
      if ((obs_vec() & m) !== e) begin
        errors++;
        $display("FAIL random cyc=%0d actual=%h required=%h", i, obs_vec() & m, e);
      end
      cycle();
    end
    clear_inputs();
    mem_rvalid_i = 1'b1;
    cycle();
    clear_inputs();
  endtask

  initial begin
    m_gi = 1'b0;
    m_gd = 1'b0;
    test_reset();
    test_single_fetch();
    test_store_priority();
    test_starvation();
    test_wait_grant();
    test_reset_mid();
    test_idle_rvalid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
